// File: rtl/demux_pkg.sv
// Shared definitions for the buffered demultiplexer: channel count,
// address width, slot state type and an address-to-one-hot helper.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // One-hot channel select for a binary channel address
  function automatic logic [NUM_CH-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
    addr_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/demux_channel_slot.sv
// One holding slot of the demultiplexer: a single-word register with an
// EMPTY/FULL state. A load always wins over a drain in the same cycle, so
// a drain-and-refill keeps the slot FULL with the new word (no bubble).
module demux_channel_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic             accept,
  output logic [WIDTH-1:0] data
);

  slot_state_t      state_r;
  slot_state_t      state_nxt_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_nxt_s;

  // Next slot state and word: load has priority, otherwise a drain empties it
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_r;
    if (load) begin
      state_nxt_s = SLOT_FULL;
      data_nxt_s  = load_data;
    end else if ((state_r == SLOT_FULL) && drain_ready) begin
      state_nxt_s = SLOT_EMPTY;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Slot state and data register; reset clears both without waiting for clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SLOT_EMPTY;
      data_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  // valid comes straight from the state register; the word stays put when EMPTY
  assign valid  = (state_r == SLOT_FULL);
  assign accept = (state_r == SLOT_EMPTY) || drain_ready;
  assign data   = data_r;

endmodule

// File: rtl/buffered_demultiplexer.sv
// Buffered 1-to-4 demultiplexer with valid/ready handshakes. Each channel
// has its own one-word slot and drains independently. Defining the macro
// DEMUX_BROADCAST_EN adds in_broadcast, which writes one word to all slots.
module buffered_demultiplexer
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    address0,
  input  logic                    address1,
`ifdef DEMUX_BROADCAST_EN
  input  logic                    in_broadcast,
`endif
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data
);

  logic [ADDR_W-1:0] addr_s;
  logic [NUM_CH-1:0] accept_s;
  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] load_s;
  logic              ready_s;

  assign addr_s = {address1, address0};

  // Upstream ready and per-slot load strobes from the addressed (or all) slots
  always_comb begin
    ready_s = accept_s[addr_s];
    sel_s   = addr_onehot(addr_s);
`ifdef DEMUX_BROADCAST_EN
    if (in_broadcast) begin
      ready_s = &accept_s;
      sel_s   = {NUM_CH{1'b1}};
    end else begin
      ready_s = accept_s[addr_s];
      sel_s   = addr_onehot(addr_s);
    end
`endif
    load_s = sel_s & {NUM_CH{in_valid & ready_s}};
  end

  assign in_ready = ready_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_channel_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_s[i]),
      .drain_ready(out_ready[i]),
      .load_data  (in_data),
      .valid      (out_valid[i]),
      .accept     (accept_s[i]),
      .data       (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_buffered_demultiplexer.sv
// Self-checking bench for buffered_demultiplexer: directed scenarios plus
// randomized traffic against a slot-array reference model.
module tb_buffered_demultiplexer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         address0;
  logic         address1;
  logic         in_broadcast;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [4*W-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  bit           m_full [4];
  logic [W-1:0] m_data [4];

  bit           record_on = 1'b0;
  logic [W-1:0] got_q[$];

  always #5 clk = ~clk;

  buffered_demultiplexer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .address0 (address0),
    .address1 (address1),
`ifdef DEMUX_BROADCAST_EN
    .in_broadcast(in_broadcast),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
    end
  endtask

  // One cycle: drive inputs, check outputs at negedge, advance model at posedge
  task automatic step(input logic v, input logic [1:0] a, input logic [W-1:0] d,
                      input logic [3:0] ordy, input logic bc, input string tag,
                      output logic acc);
    logic [3:0]   exp_v;
    logic [31:0]  exp_d;
    logic         exp_rdy;
    in_valid = v;
    {address1, address0} = a;
    in_data = d;
    out_ready = ordy;
    in_broadcast = bc;
    @(negedge clk);
    exp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_v[i] = m_full[i];
      exp_d[i*8 +: 8] = m_data[i];
      if (bc && m_full[i] && !ordy[i]) exp_rdy = 1'b0;
    end
    if (!bc) exp_rdy = !m_full[a] || ordy[a];
    check_eq({tag, "/in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    check_eq({tag, "/out_valid"}, {28'd0, out_valid}, {28'd0, exp_v});
    check_eq({tag, "/out_data"}, out_data, exp_d);
    if (record_on && out_valid[0] && out_ready[0]) got_q.push_back(out_data[7:0]);
    acc = v && exp_rdy;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (acc && (bc || a == 2'(i))) begin
        m_full[i] = 1'b1;
        m_data[i] = d;
      end else if (m_full[i] && ordy[i]) begin
        m_full[i] = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic         acc;
    logic         hv;
    logic [1:0]   ha;
    logic [W-1:0] hd;
    logic [W-1:0] sent_q[$];

    rst_n = 1'b0;
    in_valid = 1'b0;
    {address1, address0} = 2'b00;
    in_data = '0;
    out_ready = 4'b0000;
    in_broadcast = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("reset/out_valid", {28'd0, out_valid}, 32'd0);
    check_eq("reset/in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("reset/out_data", out_data, 32'd0);
    rst_n = 1'b1;

    // Basic routing: A5 to channel 2, held while stalled
    step(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0, "route_load", acc);
    for (int k = 0; k < 5; k++) step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, "route_hold", acc);
    step(1'b0, 2'd0, 8'h00, 4'b0100, 1'b0, "route_drain", acc);

    // Backpressure on channel 1, then drain-and-refill without a bubble
    step(1'b1, 2'd1, 8'h5A, 4'b0000, 1'b0, "bp_fill", acc);
    step(1'b1, 2'd1, 8'h77, 4'b0000, 1'b0, "bp_stall", acc);
    step(1'b1, 2'd1, 8'h77, 4'b0010, 1'b0, "bp_refill", acc);
    step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, "bp_newword", acc);
    step(1'b0, 2'd0, 8'h00, 4'b0010, 1'b0, "bp_drain", acc);

    // Independence: channel 3 stalled while 0/1/2 take words back-to-back
    step(1'b1, 2'd3, 8'h99, 4'b0000, 1'b0, "ind_fill3", acc);
    step(1'b1, 2'd0, 8'h11, 4'b0000, 1'b0, "ind_ch0", acc);
    step(1'b1, 2'd1, 8'h22, 4'b0000, 1'b0, "ind_ch1", acc);
    step(1'b1, 2'd2, 8'h33, 4'b0000, 1'b0, "ind_ch2", acc);
    step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, "ind_all", acc);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, "ind_drain", acc);

    // Streaming: 16 words into channel 0, one per cycle, order kept
    record_on = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 2'd0, 8'(8'h40 + k), 4'b0001, 1'b0, "stream", acc);
      if (acc) sent_q.push_back(8'(8'h40 + k));
    end
    step(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, "stream_tail", acc);
    step(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, "stream_idle", acc);
    record_on = 1'b0;
    check_eq("stream/accepted", 32'(sent_q.size()), 32'd16);
    check_eq("stream/drained", 32'(got_q.size()), 32'd16);
    for (int k = 0; k < 16 && k < got_q.size(); k++)
      check_eq("stream/order", {24'd0, got_q[k]}, 32'(8'h40 + k));

    // Randomized traffic honouring the upstream hold rule
    hv = 1'b0; ha = 2'd0; hd = '0;
    acc = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (!(hv && !acc)) begin
        hv = ($urandom_range(0, 3) != 0);
        ha = 2'($urandom_range(0, 3));
        hd = 8'($urandom);
      end
      step(hv, ha, hd, 4'($urandom), 1'b0, "rand", acc);
    end
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, "rand_flush", acc);

    // Mid-run reset with channel 2 full: everything clears without a clock edge
    step(1'b1, 2'd2, 8'hC3, 4'b0000, 1'b0, "mrst_fill", acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mrst/out_valid", {28'd0, out_valid}, 32'd0);
    check_eq("mrst/in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mrst/out_data", out_data, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 2'd3, 8'h5E, 4'b0000, 1'b0, "mrst_first", acc);
    step(1'b0, 2'd0, 8'h00, 4'b1000, 1'b0, "mrst_check", acc);

`ifdef DEMUX_BROADCAST_EN
    // Broadcast waits for stalled channel 1, then fills every slot
    step(1'b1, 2'd1, 8'h66, 4'b0000, 1'b0, "bc_fill1", acc);
    step(1'b1, 2'd0, 8'h3C, 4'b0000, 1'b1, "bc_stall", acc);
    step(1'b1, 2'd0, 8'h3C, 4'b0010, 1'b1, "bc_go", acc);
    step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, "bc_all", acc);
    check_eq("bc/out_valid", {28'd0, out_valid}, 32'h0000000F);
    check_eq("bc/out_data", out_data, 32'h3C3C3C3C);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, "bc_drain", acc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buffered_demultiplexer.md
BUFFERED_DEMULTIPLEXER -- requirements
Module: buffered_demultiplexer

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of one word.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  upstream word present.
REQ-005 SHALL have port: in_ready  output  1  block accepts word this cycle.
REQ-006 SHALL have port: in_data  input  WIDTH  upstream word.
REQ-007 SHALL have port: address0  input  1  channel select LSB.
REQ-008 SHALL have port: address1  input  1  channel select MSB.
REQ-009 SHALL have port: out_valid  output  4  per-channel word present; bit i = channel i.
REQ-010 SHALL have port: out_ready  input  4  per-channel downstream accept.
REQ-011 SHALL have port: out_data  output  4*WIDTH  channel i word at bits [i*WIDTH +: WIDTH].

Function
REQ-012 SHALL decode addr = {address1, address0} to channel 0..3.
REQ-013 SHALL give each channel one holding slot with two states, EMPTY and FULL.
REQ-014 SHALL transfer upstream when in_valid & in_ready at a rising clk edge; transfer downstream on channel i when out_valid[i] & out_ready[i].
REQ-015 SHALL drive in_ready combinationally = slot[addr] EMPTY, or slot[addr] FULL & out_ready[addr].
REQ-016 SHALL, on upstream transfer, load in_data into slot[addr] and set it FULL; out_valid[addr] rises the next cycle (latency 1).
REQ-017 SHALL, on downstream transfer with no same-cycle load, set slot EMPTY.
REQ-018 SHALL, on simultaneous drain and load of the same slot, keep it FULL with the new word; no bubble, no loss.
REQ-019 SHALL leave non-addressed slots unaffected by upstream transfers; every channel drains independently, all four possibly in the same cycle.
REQ-020 SHALL hold out_data slice i stable while out_valid[i] & !out_ready[i].
REQ-021 SHALL keep out_data slice i unchanged (last value) while slot i is EMPTY.
REQ-022 SHALL ignore in_data and address while in_valid is low; upstream SHALL hold in_data and address stable while in_valid & !in_ready.
REQ-023 SHALL derive out_valid[i] directly from the slot state register (no combinational path from inputs).

Reset
REQ-024 SHALL, on rst_n low, immediately set all slots EMPTY, out_valid = 4'b0000 and out_data = 0, independent of clk.
REQ-025 SHALL discard held words when reset is asserted mid-operation; in_ready = 1 while all slots are EMPTY.
REQ-026 SHALL accept the first word on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with DEMUX_BROADCAST_EN defined, add input in_broadcast (1 bit).
REQ-028 SHALL, with DEMUX_BROADCAST_EN defined and in_broadcast high, drive in_ready = AND over all four slots of (EMPTY or draining), and on transfer load in_data into all four slots.
REQ-029 SHALL, with DEMUX_BROADCAST_EN defined and in_broadcast low, behave exactly as without the macro.
REQ-030 SHALL, without DEMUX_BROADCAST_EN, omit in_broadcast and all broadcast logic.

Structure
REQ-031 SHALL place NUM_CH = 4, ADDR_W = 2 and the slot-state type (EMPTY, FULL) in shared package demux_pkg.
REQ-032 SHALL implement one slot as sub-module demux_channel_slot (load, drain, state, data register); instantiate it four times.

Verification
REQ-033 SHALL cover reset: hold rst_n low mid-run with slot 2 FULL -> out_valid = 0000 asynchronously, in_ready = 1.
REQ-034 SHALL cover basic routing: addr = 2, in_data = 8'hA5, one transfer, out_ready = 0000 -> next cycle out_valid = 0100, slice 2 = A5, held for 5 cycles.
REQ-035 SHALL cover backpressure: slot 1 FULL, out_ready[1] = 0, in_valid with addr = 1 -> in_ready = 0, no change; then out_ready[1] = 1 -> in_ready = 1, new word loaded with no bubble.
REQ-036 SHALL cover independence: slot 3 FULL and stalled, words 11/22/33 to channels 0/1/2 -> all accepted back-to-back, slot 3 unchanged.
REQ-037 SHALL cover streaming: continuous in_valid to addr = 0 with out_ready[0] = 1 -> one word per cycle, order preserved over 16 words.
REQ-038 SHALL cover broadcast (DEMUX_BROADCAST_EN defined): in_broadcast = 1, data 8'h3C, slot 1 stalled FULL -> in_ready = 0; after slot 1 drains -> all four slices = 3C, out_valid = 1111.
